// File: rtl/aes_decrypt_iterative_if.sv
// Handshake bundle for aes_decrypt_iterative: ciphertext/key-schedule input side
// and plaintext output side, each with its own valid/ready pair.
interface aes_decrypt_iterative_if #(
  parameter int nb = 4,
  parameter int nr = 14
);
  logic                        in_valid;
  logic                        in_ready;
  logic [32*nb-1:0]            cipher;
  logic [32*nb*(nr+1)-1:0]     w;
  logic                        out_valid;
  logic                        out_ready;
  logic [32*nb-1:0]            msg;

  modport master (
    output in_valid, cipher, w, out_ready,
    input  in_ready, out_valid, msg
  );

  modport slave (
    input  in_valid, cipher, w, out_ready,
    output in_ready, out_valid, msg
  );
endinterface

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
// Optional macro AES_DEC_LATCH_KEY_EN captures the key schedule at accept.
module aes_decrypt_iterative #(
  parameter int nk = 8,
  parameter int nb = 4,
  parameter int nr = 14
) (
  input  logic clk,
  input  logic rst,
  aes_decrypt_iterative_if.slave bus
);
  localparam int bw = 32 * nb;
  localparam int kw = bw * (nr + 1);
  localparam int rw = $clog2(nr + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (nr != nk + 6 || nb != 4) begin : g_cfg_err
    $error("aes_decrypt_iterative: nr must equal nk+6 and nb must be 4");
  end

  localparam logic [7:0] inv_sbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (r,c) lives at bit 32c + 8*(3-r); row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[32*c + 8*(3-r) +: 8] = s[32*((c - r + 4) % 4) + 8*(3-r) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv_sbox[s[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_word(input logic [31:0] a);
    logic [7:0] b, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      b     = a[8*(3-i) +: 8];
      x2    = xtime(b);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ b;
      mb[i] = x8 ^ x2 ^ b;
      md[i] = x8 ^ x4 ^ b;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[32*c +: 32] = inv_mix_word(s[32*c +: 32]);
    return o;
  endfunction

  logic [1:0]    state;
  logic [rw-1:0] rnd;
  logic [bw-1:0] state_reg;
  logic [bw-1:0] msg_reg;
  logic          out_valid_reg;
  logic [kw-1:0] keys;
  logic [bw-1:0] rk;
  logic [bw-1:0] added;
  logic [bw-1:0] mixed;
  logic          accept;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.msg       = msg_reg;
  assign accept        = bus.in_valid & bus.in_ready;

`ifdef AES_DEC_LATCH_KEY_EN
  logic [kw-1:0] key_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      key_reg <= '0;
    else if (accept)
      key_reg <= bus.w;
  end

  assign keys = key_reg;
`else
  assign keys = bus.w;
`endif

  assign rk    = keys[bw*rnd +: bw];
  assign added = inv_sub_bytes(inv_shift_rows(state_reg)) ^ rk;
  assign mixed = inv_mix_columns(added);

  // The initial whitening uses the port directly so the latched and direct builds agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rnd           <= '0;
      state_reg     <= '0;
      msg_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_reg <= bus.cipher ^ bus.w[bw*nr +: bw];
            rnd       <= rw'(nr - 1);
            state     <= RUN;
          end
        end
        RUN: begin
          if (rnd == '0) begin
            msg_reg       <= added;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            state_reg <= mixed;
            rnd       <= rnd - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Directed bench for aes_decrypt_iterative: FIPS-197 AES-128/AES-256 vectors,
// backpressure, mid-run reset and back-to-back streaming.
module tb_aes_decrypt_iterative;
  localparam logic [127:0] plain  = 128'hccddeeff_8899aabb_44556677_00112233;
  localparam logic [127:0] ct128  = 128'h70b4c55a_d8cdb780_6a7b0430_69c4e0d8;
  localparam logic [127:0] ct256  = 128'h4b496089_eafc4990_516745bf_8ea2b7ca;
  localparam logic [127:0] key128 = 128'h0c0d0e0f_08090a0b_04050607_00010203;
  localparam logic [255:0] key256 = 256'h1c1d1e1f_18191a1b_14151617_10111213_0c0d0e0f_08090a0b_04050607_00010203;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_decrypt_iterative_if #(.nb(4), .nr(14)) bus256();
  aes_decrypt_iterative_if #(.nb(4), .nr(10)) bus128();

  aes_decrypt_iterative #(.nk(8), .nb(4), .nr(14)) dut256 (.clk(clk), .rst(rst), .bus(bus256.slave));
  aes_decrypt_iterative #(.nk(4), .nb(4), .nr(10)) dut128 (.clk(clk), .rst(rst), .bus(bus128.slave));

  logic [1919:0] w256;
  logic [1919:0] wtmp;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box from first principles: field inverse then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int x = 1; x < 256; x++)
      if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    s = 8'h63 ^ inv;
    for (int n = 1; n <= 4; n++)
      s = s ^ ((inv << n) | (inv >> (8 - n)));
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nk);
    logic [1919:0] ww;
    logic [31:0]   t;
    logic [7:0]    rc;
    ww = '0;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) ww[32*i +: 32] = key[32*i +: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = ww[32*(i-1) +: 32];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      ww[32*i +: 32] = ww[32*(i-nk) +: 32] ^ t;
    end
    return ww;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [127:0] c);
    @(negedge clk);
    bus256.cipher   = c;
    bus256.w        = w256;
    bus256.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus256.in_valid = 1'b0;
`ifdef AES_DEC_LATCH_KEY_EN
    for (int i = 0; i < 60; i++) bus256.w[32*i +: 32] = $urandom();
`endif
  endtask

  task automatic wait_output(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus256.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int            lat;
    logic          okv, okm, okr, seen;
    int            n_acc, n_out;
    int            acc [2];
    logic [127:0]  outs [2];

    bus256.in_valid  = 1'b0;
    bus256.out_ready = 1'b0;
    bus256.cipher    = '0;
    bus128.in_valid  = 1'b0;
    bus128.out_ready = 1'b1;
    bus128.cipher    = '0;
    w256             = key_expand(key256, 8);
    wtmp             = key_expand({128'h0, key128}, 4);
    bus256.w         = w256;
    bus128.w         = wtmp[1407:0];

    repeat (3) @(negedge clk);
    check_output("rst in_ready256", 128'(bus256.in_ready), 128'd1);
    check_output("rst out_valid256", 128'(bus256.out_valid), 128'd0);
    check_output("rst msg256", bus256.msg, 128'd0);
    check_output("rst in_ready128", 128'(bus128.in_ready), 128'd1);
    check_output("rst out_valid128", 128'(bus128.out_valid), 128'd0);
    check_output("rst msg128", bus128.msg, 128'd0);
    rst = 1'b0;

    // AES-128 vector on the second instance
    @(negedge clk);
    bus128.cipher   = ct128;
    bus128.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus128.in_valid = 1'b0;
    check_output("busy in_ready128", 128'(bus128.in_ready), 128'd0);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus128.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check_output("aes128 latency", 128'(lat), 128'd10);
    check_output("aes128 msg", bus128.msg, plain);

    // AES-256 vector, consumer stalled
    apply_stimulus(ct256);
    check_output("busy in_ready256", 128'(bus256.in_ready), 128'd0);
    wait_output(lat);
    check_output("aes256 latency", 128'(lat), 128'd14);
    check_output("aes256 msg", bus256.msg, plain);

    okv = 1'b1;
    okm = 1'b1;
    okr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus256.out_valid !== 1'b1) okv = 1'b0;
      if (bus256.msg !== plain) okm = 1'b0;
      if (bus256.in_ready !== 1'b0) okr = 1'b0;
      @(posedge clk);
      #1;
    end
    check_output("stall out_valid held", 128'(okv), 128'd1);
    check_output("stall msg held", 128'(okm), 128'd1);
    check_output("stall in_ready low", 128'(okr), 128'd1);
    @(negedge clk);
    bus256.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("release out_valid", 128'(bus256.out_valid), 128'd0);
    check_output("release in_ready", 128'(bus256.in_ready), 128'd1);

    // Reset in the middle of a run, then resubmit
    apply_stimulus(ct256);
    seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (bus256.out_valid !== 1'b0) seen = 1'b1;
    end
    rst = 1'b1;
    #1;
    check_output("pre-reset no out_valid", 128'(seen), 128'd0);
    check_output("mid-run rst out_valid", 128'(bus256.out_valid), 128'd0);
    check_output("mid-run rst in_ready", 128'(bus256.in_ready), 128'd1);
    check_output("mid-run rst msg", bus256.msg, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("post-reset quiet", 128'(bus256.out_valid), 128'd0);
    apply_stimulus(ct256);
    wait_output(lat);
    check_output("resubmit latency", 128'(lat), 128'd14);
    check_output("resubmit msg", bus256.msg, plain);

    // Two blocks streamed with in_valid and out_ready held high
    @(posedge clk);
    #1;
    n_acc   = 0;
    n_out   = 0;
    acc[0]  = 0;
    acc[1]  = 0;
    outs[0] = '0;
    outs[1] = '0;
    @(negedge clk);
    bus256.cipher   = ct256;
    bus256.w        = w256;
    bus256.in_valid = 1'b1;
    for (int k = 0; k < 80 && n_out < 2; k++) begin
      if (n_acc == 2) bus256.in_valid = 1'b0;
      if (bus256.in_valid && bus256.in_ready && n_acc < 2) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (bus256.out_valid && bus256.out_ready) begin
        outs[n_out] = bus256.msg;
        n_out++;
      end
      @(negedge clk);
    end
    bus256.in_valid = 1'b0;
    check_output("stream accepts", 128'(n_acc), 128'd2);
    check_output("stream spacing", 128'(acc[1] - acc[0]), 128'd16);
    check_output("stream outputs", 128'(n_out), 128'd2);
    check_output("stream msg0", outs[0], plain);
    check_output("stream msg1", outs[1], plain);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
